// File: rtl/host_stream_loader_if.sv
// rtl/host_stream_loader_if.sv - host word stream handshake between host side and loader
interface host_stream_loader_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/host_stream_loader.sv
// rtl/host_stream_loader.sv - decodes host LOAD/START headers into buffer writes and a start pulse
module host_stream_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_CH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  host_stream_loader_if.slave  s,
  output logic [NUM_CH-1:0]    wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 start,
  input  logic                 tpu_done,
  output logic                 busy,
  output logic                 err
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PULSE, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [NUM_CH-1:0]   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   hdr_cnt;
  logic [ADDR_W-1:0]   hdr_base;
  logic [CH_W-1:0]     hdr_ch;
  logic [1:0]          hdr_op;
  logic                hdr_ch_ok;
  logic                accept;

  assign hdr_cnt   = s.s_data[ADDR_W-1:0];
  assign hdr_base  = s.s_data[2*ADDR_W-1:ADDR_W];
  assign hdr_ch    = s.s_data[2*ADDR_W+CH_W-1:2*ADDR_W];
  assign hdr_op    = s.s_data[DATA_W-1:DATA_W-2];
  assign hdr_ch_ok = ({{(32-CH_W){1'b0}}, hdr_ch} < NUM_CH);

  // Ready depends on state alone so the host never sees a valid-to-ready loop.
  assign s.s_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept    = s.s_valid && s.s_ready;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (hdr_op)
            2'b00: begin
              if (hdr_ch_ok) begin
                state_d = ST_LOAD;
                ch_d    = hdr_ch;
                base_d  = hdr_base;
                cnt_d   = hdr_cnt;
                idx_d   = '0;
              end else begin
                err_d = 1'b1;
              end
            end
            2'b01: begin
              state_d = ST_PULSE;
              start_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en_d   = NUM_CH'(1) << ch_q;
          wr_addr_d = base_q + idx_q;
          wr_data_d = s.s_data;
          idx_d     = idx_q + ADDR_W'(1);
          if (idx_q == cnt_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PULSE: state_d = ST_RUN;
      ST_RUN: begin
        if (tpu_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign err     = err_q;
endmodule

// File: tb/tb_host_stream_loader.sv
// tb/tb_host_stream_loader.sv - self-checking bench for host_stream_loader
module tb_host_stream_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        tpu_done;
  logic [1:0]  wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start, busy, err;
  logic [2:0]  wr_en3;
  logic [3:0]  wr_addr3;
  logic [15:0] wr_data3;
  logic        start3, busy3, err3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cnt = 0;

  typedef struct {
    logic [1:0]  en;
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;
  wr_t obs_q[$];
  wr_t exp_q[$];

  host_stream_loader_if #(.DATA_W(16)) hif ();
  host_stream_loader_if #(.DATA_W(16)) hif3 ();

  host_stream_loader #(.DATA_W(16), .ADDR_W(4), .NUM_CH(2)) dut (
    .clk(clk), .reset(reset), .s(hif.slave), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .tpu_done(tpu_done), .busy(busy), .err(err)
  );

  host_stream_loader #(.DATA_W(16), .ADDR_W(4), .NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .s(hif3.slave), .wr_en(wr_en3), .wr_addr(wr_addr3),
    .wr_data(wr_data3), .start(start3), .tpu_done(tpu_done), .busy(busy3), .err(err3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en !== 2'b00) obs_q.push_back('{wr_en, wr_addr, wr_data, cyc});
    if (start === 1'b1) start_cnt++;
  end

  // Every task begins and ends 1 time unit after a rising edge.
  task automatic send(input logic [15:0] w, input int gap);
    bit done = 0;
    int t = 0;
    for (int g = 0; g < gap; g++) begin
      hif.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    hif.s_valid = 1'b1;
    hif.s_data  = w;
    while (!done && t < 50) begin
      if (hif.s_ready) done = 1;
      @(posedge clk); #1;
      t++;
    end
    hif.s_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout word=%h never accepted", w);
    end
  endtask

  task automatic send3(input logic [15:0] w);
    bit done = 0;
    int t = 0;
    hif3.s_valid = 1'b1;
    hif3.s_data  = w;
    while (!done && t < 50) begin
      if (hif3.s_ready) done = 1;
      @(posedge clk); #1;
      t++;
    end
    hif3.s_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send3_timeout word=%h never accepted", w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; tpu_done = 1'b0;
    hif.s_valid = 1'b0; hif.s_data = '0;
    hif3.s_valid = 1'b0; hif3.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, start, busy, err} !== 27'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=0", {wr_en, wr_addr, wr_data, start, busy, err});
    end
    n_checks++;
    if ({wr_en3, start3, busy3, err3} !== 6'd0) begin
      n_fail++; $display("FAIL reset_outputs3 got=%h want=0", {wr_en3, start3, busy3, err3});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (hif.s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got=%b want=1", hif.s_ready);
    end
  endtask

  task automatic test_load_b2b();
    logic [15:0] d [3];
    d[0] = 16'h00A0; d[1] = 16'h00A1; d[2] = 16'h00A2;
    obs_q.delete();
    send(16'h0052, 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_hdr got=%b want=1", busy); end
    for (int i = 0; i < 3; i++) send(d[i], 0);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got=%b want=0", busy); end
    @(posedge clk); #1;
    n_checks++;
    if (obs_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_count got=%0d want=3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_q[i].en !== 2'b01 || obs_q[i].addr !== 4'(5 + i) || obs_q[i].data !== d[i]) begin
          n_fail++; $display("FAIL b2b_write%0d got=%b/%h/%h want=01/%h/%h", i,
                             obs_q[i].en, obs_q[i].addr, obs_q[i].data, 4'(5 + i), d[i]);
        end
      end
      n_checks++;
      if (obs_q[2].cyc - obs_q[0].cyc != 2) begin
        n_fail++; $display("FAIL b2b_consecutive got_span=%0d want=2", obs_q[2].cyc - obs_q[0].cyc);
      end
    end
  endtask

  task automatic test_load_stall_wrap();
    logic [3:0] want_addr [4];
    want_addr[0] = 4'd14; want_addr[1] = 4'd15; want_addr[2] = 4'd0; want_addr[3] = 4'd1;
    obs_q.delete();
    send(16'h01E3, 0);
    for (int i = 0; i < 4; i++) send(16'hB000 + 16'(i), 1);
    @(posedge clk); #1;
    n_checks++;
    if (obs_q.size() != 4) begin
      n_fail++; $display("FAIL stall_count got=%0d want=4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (obs_q[i].en !== 2'b10 || obs_q[i].addr !== want_addr[i] || obs_q[i].data !== 16'hB000 + 16'(i)) begin
          n_fail++; $display("FAIL stall_write%0d got=%b/%h/%h want=10/%h/%h", i,
                             obs_q[i].en, obs_q[i].addr, obs_q[i].data, want_addr[i], 16'hB000 + 16'(i));
        end
        if (i > 0) begin
          n_checks++;
          if (obs_q[i].cyc - obs_q[i-1].cyc != 2) begin
            n_fail++; $display("FAIL stall_spacing%0d got=%0d want=2", i, obs_q[i].cyc - obs_q[i-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_start();
    int sc = start_cnt;
    send(16'h4000, 0);
    n_checks++;
    if (start !== 1'b1 || hif.s_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_pulse got start/ready/busy=%b%b%b want=101", start, hif.s_ready, busy);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (hif.s_ready !== 1'b0 || start !== 1'b0) begin
        n_fail++; $display("FAIL start_wait%0d got ready/start=%b%b want=00", i, hif.s_ready, start);
      end
    end
    tpu_done = 1'b1;
    @(posedge clk); #1;
    tpu_done = 1'b0;
    n_checks++;
    if (hif.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_done got ready/busy=%b%b want=10", hif.s_ready, busy);
    end
    n_checks++;
    if (start_cnt - sc != 1) begin
      n_fail++; $display("FAIL start_count got=%0d want=1", start_cnt - sc);
    end
  endtask

  task automatic test_early_done();
    send(16'h4000, 0);
    tpu_done = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (hif.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL early_done_ignored got ready=%b want=0", hif.s_ready);
    end
    @(posedge clk); #1;
    tpu_done = 1'b0;
    n_checks++;
    if (hif.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL early_done_exit got ready/busy=%b%b want=10", hif.s_ready, busy);
    end
  endtask

  task automatic test_reserved();
    int sc = start_cnt;
    obs_q.delete();
    send(16'h8000, 0);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reserved_err got err/busy=%b%b want=10", err, busy);
    end
    send(16'h0010, 0);
    send(16'h1234, 0);
    @(posedge clk); #1;
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL reserved_follow_count got=%0d want=1", obs_q.size());
    end else if (obs_q[0].en !== 2'b01 || obs_q[0].addr !== 4'd1 || obs_q[0].data !== 16'h1234) begin
      n_fail++; $display("FAIL reserved_follow_write got=%b/%h/%h want=01/1/1234",
                         obs_q[0].en, obs_q[0].addr, obs_q[0].data);
    end
    n_checks++;
    if (err !== 1'b1 || start_cnt != sc) begin
      n_fail++; $display("FAIL reserved_sticky got err=%b starts=%0d want err=1 starts=0", err, start_cnt - sc);
    end
  endtask

  task automatic test_bad_channel();
    send3(16'h0300);
    n_checks++;
    if (err3 !== 1'b1 || busy3 !== 1'b0 || wr_en3 !== 3'b000) begin
      n_fail++; $display("FAIL badch got err/busy/wr_en=%b%b%b want=1 0 000", err3, busy3, wr_en3);
    end
    send3(16'h0230);
    send3(16'hCAFE);
    n_checks++;
    if (wr_en3 !== 3'b100 || wr_addr3 !== 4'd3 || wr_data3 !== 16'hCAFE) begin
      n_fail++; $display("FAIL ch2_write got=%b/%h/%h want=100/3/cafe", wr_en3, wr_addr3, wr_data3);
    end
  endtask

  task automatic test_mid_reset();
    send(16'h0003, 0);
    send(16'h1111, 0);
    send(16'h2222, 0);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, start, busy, err} !== 27'd0) begin
      n_fail++; $display("FAIL midreset_outputs got=%h want=0", {wr_en, wr_addr, wr_data, start, busy, err});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
    send(16'h4000, 0);
    n_checks++;
    if (start !== 1'b1 || obs_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_header got start=%b writes=%0d want start=1 writes=0", start, obs_q.size());
    end
    tpu_done = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    tpu_done = 1'b0;
  endtask

  task automatic test_random();
    int sc = start_cnt;
    obs_q.delete();
    exp_q.delete();
    for (int c = 0; c < 24; c++) begin
      int kind = $urandom_range(0, 5);
      if (kind == 0) begin
        send(16'hC000 | 16'($urandom_range(0, 16'h3FFF)), $urandom_range(0, 2));
      end else begin
        int ch   = $urandom_range(0, 1);
        int base = $urandom_range(0, 15);
        int cnt  = $urandom_range(1, 16);
        send(16'((ch << 8) | (base << 4) | (cnt - 1)) | (16'($urandom_range(0, 63)) << 9 & 16'h3E00),
             $urandom_range(0, 2));
        for (int i = 0; i < cnt; i++) begin
          logic [15:0] w = 16'($urandom);
          wr_t e;
          e.en = 2'(1 << ch); e.addr = 4'((base + i) % 16); e.data = w; e.cyc = 0;
          exp_q.push_back(e);
          send(w, $urandom_range(0, 2));
        end
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end else begin
      int bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i].en !== exp_q[i].en || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
          if (bad < 5) $display("FAIL rand_write%0d got=%b/%h/%h want=%b/%h/%h", i, obs_q[i].en,
                                obs_q[i].addr, obs_q[i].data, exp_q[i].en, exp_q[i].addr, exp_q[i].data);
          bad++;
        end
      end
      n_checks++;
      if (bad != 0) n_fail++;
    end
    n_checks++;
    if (start_cnt != sc || busy !== 1'b0) begin
      n_fail++; $display("FAIL rand_tail got starts=%0d busy=%b want 0 0", start_cnt - sc, busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_load_stall_wrap();
    test_start();
    test_early_done();
    test_reserved();
    test_bad_channel();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
